// File: rtl/id_ex_stage.sv
// -----------------------------------------------------------------------------
// id_ex_stage
//
// ID/EX pipeline register sitting directly behind the 8-entry register file.
// It captures operands, decoded control and the immediate for the instruction
// in decode. RAW hazards are resolved by forwarding from EX, MEM and WB. A
// load-use hazard costs one stall cycle, during which a bubble goes into EX.
//
// Ports
//   clk, rst_n              clock, synchronous active-low reset
//   id_*                    decode-slot instruction (addresses, flags, ctrl, imm)
//   rf_a, rf_b              register-file read data for id_ra / id_rb
//   ex_result               combinational ALU result of the instruction in EX
//   mem_rd/regwrite/data    MEM-stage writeback bypass
//   wb_rd/regwrite/data     WB-stage writeback bypass (register-file write port)
//   freeze                  external memory stall; holds every register
//   flush                   squash the decode-slot instruction
//   stall_o                 hold PC and IF/ID (load-use stall)
//   ex_*                    registered EX-slot outputs
//   stall_count             saturating count of load-use stall cycles
//
// FSM states
//   state     | meaning
//   ST_RUN    | normal capture; a load-use hazard raises stall_o
//   ST_BUBBLE | bubble is in EX, load is in MEM; capture resumes normally
// -----------------------------------------------------------------------------
module id_ex_stage #(
    parameter int CTRL_W = 6,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_ra,
    input  logic [ADDR_W-1:0] id_rb,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_uses_a,
    input  logic              id_uses_b,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic [CTRL_W-1:0] id_ctrl,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [DATA_W-1:0] rf_a,
    input  logic [DATA_W-1:0] rf_b,
    input  logic [DATA_W-1:0] ex_result,
    input  logic [ADDR_W-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [DATA_W-1:0] mem_data,
    input  logic [ADDR_W-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic [DATA_W-1:0] wb_data,
    input  logic              freeze,
    input  logic              flush,
    output logic              stall_o,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_opa,
    output logic [DATA_W-1:0] ex_opb,
    output logic [DATA_W-1:0] ex_imm,
    output logic [ADDR_W-1:0] ex_rd,
    output logic              ex_regwrite,
    output logic              ex_memread,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [7:0]        stall_count
);

    // Registers 0 and 7 are constants; they are never written and never forwarded.
    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
    localparam logic [ADDR_W-1:0] REG_HI   = ADDR_W'(7);
    localparam logic [DATA_W-1:0] VAL_HI   = DATA_W'(8'h7F);

    typedef enum logic [0:0] {
        ST_RUN    = 1'b0,
        ST_BUBBLE = 1'b1
    } state_t;

    state_t             state_q, state_d;

    logic               ex_valid_q,    ex_valid_d;
    logic [DATA_W-1:0]  ex_opa_q,      ex_opa_d;
    logic [DATA_W-1:0]  ex_opb_q,      ex_opb_d;
    logic [DATA_W-1:0]  ex_imm_q,      ex_imm_d;
    logic [ADDR_W-1:0]  ex_rd_q,       ex_rd_d;
    logic               ex_regwrite_q, ex_regwrite_d;
    logic               ex_memread_q,  ex_memread_d;
    logic [CTRL_W-1:0]  ex_ctrl_q,     ex_ctrl_d;
    logic [7:0]         stall_cnt_q,   stall_cnt_d;

    logic               ex_fwd_en;
    logic               hazard_a;
    logic               hazard_b;
    logic               hazard;
    logic               bubble;
    logic [DATA_W-1:0]  opa_sel;
    logic [DATA_W-1:0]  opb_sel;

    function automatic logic is_const_reg(input logic [ADDR_W-1:0] addr);
        return (addr == REG_ZERO) || (addr == REG_HI);
    endfunction

    // Youngest producer wins. A load in EX is excluded: its data does not
    // exist yet, which is exactly the load-use case handled by the stall.
    function automatic logic [DATA_W-1:0] select_operand(
        input logic [ADDR_W-1:0] src,
        input logic [DATA_W-1:0] rf_val,
        input logic              ex_en,
        input logic [ADDR_W-1:0] ex_dst,
        input logic [DATA_W-1:0] ex_val,
        input logic              mem_en,
        input logic [ADDR_W-1:0] mem_dst,
        input logic [DATA_W-1:0] mem_val,
        input logic              wb_en,
        input logic [ADDR_W-1:0] wb_dst,
        input logic [DATA_W-1:0] wb_val
    );
        logic [DATA_W-1:0] res;
        res = rf_val;
        if (src == REG_ZERO) begin
            res = '0;
        end else if (src == REG_HI) begin
            res = VAL_HI;
        end else if (ex_en && (ex_dst == src)) begin
            res = ex_val;
        end else if (mem_en && (mem_dst == src)) begin
            res = mem_val;
        end else if (wb_en && (wb_dst == src)) begin
            // register-file write lands after the edge, so bypass it here
            res = wb_val;
        end
        return res;
    endfunction

    assign ex_fwd_en = ex_valid_q & ex_regwrite_q & ~ex_memread_q;

    always_comb begin
        opa_sel = select_operand(id_ra, rf_a,
                                 ex_fwd_en, ex_rd_q, ex_result,
                                 mem_regwrite, mem_rd, mem_data,
                                 wb_regwrite, wb_rd, wb_data);
        opb_sel = select_operand(id_rb, rf_b,
                                 ex_fwd_en, ex_rd_q, ex_result,
                                 mem_regwrite, mem_rd, mem_data,
                                 wb_regwrite, wb_rd, wb_data);
    end

    // Load-use detection; needs ex_valid, so it can never fire while a bubble
    // sits in EX.
    assign hazard_a = id_uses_a & (ex_rd_q == id_ra) & ~is_const_reg(id_ra);
    assign hazard_b = id_uses_b & (ex_rd_q == id_rb) & ~is_const_reg(id_rb);
    assign hazard   = ex_valid_q & ex_memread_q & ex_regwrite_q & id_valid
                    & (hazard_a | hazard_b);

    // FSM next state and stall output
    always_comb begin
        state_d = state_q;
        stall_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                if (hazard && !freeze && !flush) begin
                    stall_o = 1'b1;
                    state_d = ST_BUBBLE;
                end
            end
            ST_BUBBLE: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // flush always lands in RUN; a coinciding hazard is absorbed by the
        // flush bubble instead of adding a second one
        if (flush) begin
            state_d = ST_RUN;
        end
    end

    // An empty, flushed or stalled slot enters EX as an all-zero bubble.
    assign bubble = flush | stall_o | ~id_valid;

    always_comb begin
        ex_valid_d    = 1'b0;
        ex_opa_d      = '0;
        ex_opb_d      = '0;
        ex_imm_d      = '0;
        ex_rd_d       = '0;
        ex_regwrite_d = 1'b0;
        ex_memread_d  = 1'b0;
        ex_ctrl_d     = '0;
        if (!bubble) begin
            ex_valid_d    = 1'b1;
            ex_opa_d      = opa_sel;
            ex_opb_d      = opb_sel;
            ex_imm_d      = id_imm;
            ex_rd_d       = id_rd;
            ex_regwrite_d = id_regwrite;
            ex_memread_d  = id_memread;
            ex_ctrl_d     = id_ctrl;
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_o && (stall_cnt_q != 8'hFF)) begin
            stall_cnt_d = stall_cnt_q + 8'd1;
        end
    end

    // freeze holds everything; reset still wins over it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            ex_valid_q    <= 1'b0;
            ex_opa_q      <= '0;
            ex_opb_q      <= '0;
            ex_imm_q      <= '0;
            ex_rd_q       <= '0;
            ex_regwrite_q <= 1'b0;
            ex_memread_q  <= 1'b0;
            ex_ctrl_q     <= '0;
            stall_cnt_q   <= '0;
        end else if (!freeze) begin
            state_q       <= state_d;
            ex_valid_q    <= ex_valid_d;
            ex_opa_q      <= ex_opa_d;
            ex_opb_q      <= ex_opb_d;
            ex_imm_q      <= ex_imm_d;
            ex_rd_q       <= ex_rd_d;
            ex_regwrite_q <= ex_regwrite_d;
            ex_memread_q  <= ex_memread_d;
            ex_ctrl_q     <= ex_ctrl_d;
            stall_cnt_q   <= stall_cnt_d;
        end
    end

    assign ex_valid    = ex_valid_q;
    assign ex_opa      = ex_opa_q;
    assign ex_opb      = ex_opb_q;
    assign ex_imm      = ex_imm_q;
    assign ex_rd       = ex_rd_q;
    assign ex_regwrite = ex_regwrite_q;
    assign ex_memread  = ex_memread_q;
    assign ex_ctrl     = ex_ctrl_q;
    assign stall_count = stall_cnt_q;

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline stage directly downstream of the 8-entry register file.
- Captures the register-file read data (A/B), decoded control and immediate for the instruction in decode.
- Resolves RAW hazards by forwarding from EX, MEM and WB, and detects load-use hazards, issuing a one-cycle stall with bubble insertion.
- Supports external freeze (memory stall) and flush (taken branch), and keeps a saturating stall counter for performance debug.

Parameters:
- CTRL_W, 6, width of decoded control bundle passed through to EX.
- DATA_W, 8, operand/result width.
- ADDR_W, 3, register address width (8 registers).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst_n  in  1  synchronous active-low reset.
- id_valid  in  1  decode slot holds a real instruction.
- id_ra  in  ADDR_W  source A address (same value driven to register-file RA).
- id_rb  in  ADDR_W  source B address (same value driven to register-file RB).
- id_rd  in  ADDR_W  destination address.
- id_uses_a  in  1  instruction reads source A.
- id_uses_b  in  1  instruction reads source B.
- id_regwrite  in  1  instruction writes id_rd.
- id_memread  in  1  instruction is a load.
- id_ctrl  in  CTRL_W  remaining decoded control.
- id_imm  in  DATA_W  immediate.
- rf_a  in  DATA_W  register-file output A.
- rf_b  in  DATA_W  register-file output B.
- ex_result  in  DATA_W  combinational ALU result of the instruction currently in EX (this block's outputs).
- mem_rd  in  ADDR_W  MEM-stage destination.
- mem_regwrite  in  1  MEM-stage write enable.
- mem_data  in  DATA_W  MEM-stage result.
- wb_rd  in  ADDR_W  WB-stage destination (the register-file RDo).
- wb_regwrite  in  1  WB-stage write enable (the register-file RegWrite).
- wb_data  in  DATA_W  WB write data (the register-file Mem_to_Reg).
- freeze  in  1  hold all state (external memory stall).
- flush  in  1  squash the decode-slot instruction.
- stall_o  out  1  hold PC and IF/ID this cycle.
- ex_valid  out  1  EX slot valid.
- ex_opa  out  DATA_W  forwarded operand A.
- ex_opb  out  DATA_W  forwarded operand B.
- ex_imm  out  DATA_W  registered immediate.
- ex_rd  out  ADDR_W  registered destination.
- ex_regwrite  out  1  registered write enable.
- ex_memread  out  1  registered load flag.
- ex_ctrl  out  CTRL_W  registered control bundle.
- stall_count  out  8  saturating count of load-use stall cycles.

Behaviour:
- Reset (rst_n=0 at posedge): all outputs are 0, including ex_valid, all ex_* outputs, stall_count and the FSM (RUN). stall_o is combinational and is 0 while ex_valid=0. Reset overrides freeze and flush.
- Hard-wired registers:
  - Address 0 always reads 8'h00; address 7 always reads 8'h7F.
  - Forwarding never applies to source address 0 or 7.
  - A write-enable to rd 0 or 7 never matches any source.
- Operand select for A (B identical, using id_rb/rf_b), highest priority first:
  1. ex_valid & ex_regwrite & !ex_memread & ex_rd==id_ra → ex_result.
  2. mem_regwrite & mem_rd==id_ra → mem_data.
  3. wb_regwrite & wb_rd==id_ra → wb_data. This bypass is required because register-file writes land after the edge.
  4. Otherwise rf_a.
- Load-use hazard: ex_valid & ex_memread & ex_regwrite & id_valid & ((id_uses_a & ex_rd==id_ra) | (id_uses_b & ex_rd==id_rb)), with the matching source not 0 or 7.
- FSM:
  - RUN: on hazard (and !freeze, !flush), stall_o=1 and go to BUBBLE. At the next edge, a bubble is captured (ex_valid=0, ex_regwrite=0, ex_memread=0); the decode slot is held.
  - BUBBLE: stall_o=0. The load is now in MEM, so priority 2 resolves the operand. Capture normally, then return to RUN.
  - A hazard can never be raised in BUBBLE, because ex_valid=0.
- freeze=1: no state, output or counter changes; stall_o=0 (the external stall already holds upstream). freeze has priority over flush and hazard.
- flush=1 (freeze=0): capture a bubble, force the FSM to RUN and stall_o=0. A flush coinciding with a hazard yields a single bubble, not two.
- Normal capture latency: 1 cycle from decode to ex_* outputs.
- stall_count increments by 1 on every edge where stall_o=1, and saturates at 8'hFF.

Test Plan:
- Reset with junk inputs and rst_n=0 for 2 cycles → all ex_* = 0, stall_count=0, stall_o=0; then rst_n=1 with id_valid=0 → outputs stay 0.
- EX writes r3 with ex_result=8'h21, MEM writes r3 with 8'h55, rf_a=8'h10; decode reads RA=3 → ex_opa=8'h21. Drop EX → 8'h55. Drop MEM, WB writes r3 with 8'h99 → 8'h99.
- Load in EX with ex_rd=2; decode uses RB=2 → stall_o=1 for exactly 1 cycle and ex_valid=0 for one cycle. Next cycle mem_data=8'hA5 → ex_opb=8'hA5; stall_count=1.
- Source RA=7 with EX writing r7 (ex_result=8'h00) → ex_opa=8'h7F. RA=0 with WB writing r0 (8'hFF) → ex_opa=8'h00. Load to r0 with decode using r0 → no stall.
- Hazard and flush in the same cycle → ex_valid=0 for one cycle, stall_o=0, FSM in RUN. Hazard with freeze=1 for 3 cycles → outputs frozen, stall_count unchanged, then a normal stall.
- 300 forced load-use stalls → stall_count=8'hFF. rst_n=0 mid-BUBBLE → FSM RUN, ex_valid=0.
